stack_exec: RTL
===============

STACK_EXEC -- requirements
Module: stack_exec

Interface
REQ-001: Parameter N, default 8, SHALL be the depth of the downstream stack in entries; it bounds the occupancy counter.
REQ-002: clk  input  1  single rising-edge clock for all state.
REQ-003: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004: instr_valid  input  1  instruction offered this cycle.
REQ-005: instr_ready  output  1  instruction accepted when instr_valid and instr_ready are both high at a rising edge.
REQ-006: opcode  input  4  operation; 0 NOP, 1 PUSHI, 2 POP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR, 9 NOT, 10 SHL, 11 SHR, 12 MUL, 14 EQ, 13/15 illegal.
REQ-007: imm  input  16  immediate for PUSHI.
REQ-008: qtop  input  16  current stack top.
REQ-009: qnext  input  16  current stack second entry.
REQ-010: d  output  16  write data to stack top.
REQ-011: load  output  1  stack writes d into top; takes priority over pop at the stack.
REQ-012: push  output  1  stack shifts entries down, one level deeper.
REQ-013: pop  output  1  stack shifts entries up, one level shallower.
REQ-014: busy  output  1  multi-cycle operation in progress.
REQ-015: err  output  1  sticky fault flag.
REQ-016: depth  output  $clog2(N+1)  current stack occupancy, 0..N.

Function
REQ-017: FSM states SHALL be IDLE, MUL, WB; instr_ready SHALL be high only in IDLE.
REQ-018: In IDLE, accepted non-MUL ops SHALL drive load/push/pop/d combinationally in the acceptance cycle, giving one instruction per cycle throughput.
REQ-019: Strobes SHALL be PUSHI load+push with d=imm; DUP push only; POP pop only; NOP none.
REQ-020: Binary ops SHALL assert load+pop with d = ADD qnext+qtop, SUB qnext-qtop, AND, OR, XOR, EQ {15'b0, qnext==qtop}.
REQ-021: Unary ops SHALL assert load only, with d = NOT ~qtop, SHL qtop<<1, SHR qtop>>1 (logical).
REQ-022: All arithmetic SHALL be modulo 2^16; carries and overflow are discarded without flagging.
REQ-023: When no instruction is accepted, load, push and pop SHALL all be 0; d SHALL be 0.
REQ-024: Depth SHALL change after acceptance by +1 for PUSHI/DUP, -1 for POP and binary ops, and 0 for unary ops and NOP.
REQ-025: Precondition checks SHALL be PUSHI depth<N; DUP 1<=depth<N; POP/unary depth>=1; binary/MUL depth>=2.
REQ-026: A violated precondition or illegal opcode SHALL still be accepted, drive no strobes, leave depth unchanged, and set err.
REQ-027: err SHALL remain set until reset; later instructions SHALL execute normally while err is set.
REQ-028: MUL accepted at edge T SHALL latch qtop and qnext, enter MUL, drop instr_ready and raise busy.
REQ-029: MUL SHALL be a shift-add over 16 cycles using a 4-bit iteration counter, with no stack strobes during those cycles.
REQ-030: After the 16th iteration the FSM SHALL enter WB for one cycle, assert load+pop with d = low 16 bits of the product, and decrement depth.
REQ-031: After WB the FSM SHALL return to IDLE; the first cycle with instr_ready high again is T+18.
REQ-032: busy SHALL be high in MUL and WB only.
REQ-033: instr_valid and opcode changes while instr_ready is low SHALL be ignored.

Reset
REQ-034: Reset SHALL force IDLE, depth=0, err=0, busy=0, instr_ready=1, strobes=0, d=0, and clear multiplier registers.
REQ-035: Reset asserted during MUL or WB SHALL abort the operation with no strobe emitted.

Verification
REQ-036: After reset, PUSHI 5 then PUSHI 7 then ADD -> load+push d=5, load+push d=7, then load+pop d=12; depth 1.
REQ-037: Stack holds qtop=3, qnext=10 at depth 2, issue SUB -> d=7; then SHR -> d=3; depth 1.
REQ-038: depth 2, qtop=300, qnext=300, issue MUL -> busy for 17 cycles, single load+pop d=0x5F90 (90000 mod 65536), instr_ready high at T+18, depth 1.
REQ-039: At depth 0, issue POP -> no strobes, err=1, depth 0; then PUSHI 1 -> executes normally, err stays 1.
REQ-040: With N=8, issue 8 PUSHI then DUP -> DUP drives no strobes, err=1, depth 8.
REQ-041: Assert reset at the 5th MUL cycle -> busy=0, depth=0, err=0 immediately, and no load/pop afterwards.

Source files
------------

// File: rtl/stack_exec.sv
// -----------------------------------------------------------------------------
// stack_exec
//
// Execution unit sitting in front of a hardware stack. It accepts one
// instruction per cycle, checks it against the current occupancy, and drives
// the stack's load/push/pop strobes plus write data in the same cycle. MUL is
// the only multi-cycle operation: a 16-step shift-add followed by a single
// write-back cycle.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high; clears all state immediately
//   instr_valid  instruction offered this cycle
//   instr_ready  high only in IDLE (and never while reset is asserted)
//   opcode[3:0]  operation code
//   imm[15:0]    immediate for PUSHI
//   qtop[15:0]   current stack top
//   qnext[15:0]  current stack second entry
//   d[15:0]      write data to stack top (0 whenever load is low)
//   load         stack writes d into top
//   push         stack shifts entries one level deeper
//   pop          stack shifts entries one level shallower
//   busy         multiply (MUL or WB state) in progress
//   err          sticky fault flag, cleared only by reset
//   depth        stack occupancy, 0..N
// -----------------------------------------------------------------------------
module stack_exec #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [3:0]               opcode,
    input  logic [15:0]              imm,
    input  logic [15:0]              qtop,
    input  logic [15:0]              qnext,
    output logic [15:0]              d,
    output logic                     load,
    output logic                     push,
    output logic                     pop,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(N+1)-1:0]   depth
);

    localparam int DW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_POP   = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_SHL   = 4'd10;
    localparam logic [3:0] OP_SHR   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_EQ    = 4'd14;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(N);
    localparam logic [DW-1:0] DEPTH_ONE = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

    logic [1:0]    state_q,  state_d;
    logic [DW-1:0] depth_q,  depth_d;
    logic          err_q,    err_d;
    logic [15:0]   mcand_q,  mcand_d;   // shifted left each step
    logic [15:0]   mplier_q, mplier_d;  // shifted right each step, LSB selects add
    logic [15:0]   acc_q,    acc_d;     // running product, kept modulo 2^16
    logic [3:0]    cnt_q,    cnt_d;

    logic          accept_s;
    logic          depth_ge1_s;
    logic          depth_ge2_s;
    logic          depth_lt_max_s;
    logic [15:0]   bin_res_s;
    logic [15:0]   un_res_s;
    logic          load_s;
    logic          push_s;
    logic          pop_s;
    logic [15:0]   d_s;

    // Handshake and occupancy qualifiers; ready is masked during reset so
    // nothing can be accepted while state is being cleared.
    always_comb begin
        instr_ready    = (state_q == ST_IDLE) && !reset;
        accept_s       = instr_valid && instr_ready;
        depth_ge1_s    = (depth_q >= DEPTH_ONE);
        depth_ge2_s    = (depth_q >= DEPTH_TWO);
        depth_lt_max_s = (depth_q < DEPTH_MAX);
    end

    // Two-operand results: second entry is the left operand, top the right.
    always_comb begin
        bin_res_s = 16'h0000;
        case (opcode)
            OP_ADD:  bin_res_s = qnext + qtop;
            OP_SUB:  bin_res_s = qnext - qtop;
            OP_AND:  bin_res_s = qnext & qtop;
            OP_OR:   bin_res_s = qnext | qtop;
            OP_XOR:  bin_res_s = qnext ^ qtop;
            OP_EQ:   bin_res_s = {15'b0, (qnext == qtop)};
            default: bin_res_s = 16'h0000;
        endcase
    end

    // Single-operand results on the stack top; SHR is a logical shift.
    always_comb begin
        un_res_s = 16'h0000;
        case (opcode)
            OP_NOT:  un_res_s = ~qtop;
            OP_SHL:  un_res_s = {qtop[14:0], 1'b0};
            OP_SHR:  un_res_s = {1'b0, qtop[15:1]};
            default: un_res_s = 16'h0000;
        endcase
    end

    // Next-state, strobe and occupancy logic for the IDLE/MUL/WB sequencer.
    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        err_d    = err_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        d_s      = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    // A failed precondition is still consumed: no strobes,
                    // depth held, fault flag raised.
                    case (opcode)
                        OP_NOP: begin
                            err_d = err_q;
                        end
                        OP_PUSHI: begin
                            if (depth_lt_max_s) begin
                                load_s  = 1'b1;
                                push_s  = 1'b1;
                                d_s     = imm;
                                depth_d = depth_q + DEPTH_ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_DUP: begin
                            if (depth_ge1_s && depth_lt_max_s) begin
                                push_s  = 1'b1;
                                depth_d = depth_q + DEPTH_ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (depth_ge1_s) begin
                                pop_s   = 1'b1;
                                depth_d = depth_q - DEPTH_ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_EQ: begin
                            if (depth_ge2_s) begin
                                load_s  = 1'b1;
                                pop_s   = 1'b1;
                                d_s     = bin_res_s;
                                depth_d = depth_q - DEPTH_ONE;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_NOT, OP_SHL, OP_SHR: begin
                            if (depth_ge1_s) begin
                                load_s = 1'b1;
                                d_s    = un_res_s;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_MUL: begin
                            if (depth_ge2_s) begin
                                state_d  = ST_MUL;
                                mcand_d  = qtop;
                                mplier_d = qnext;
                                acc_d    = 16'h0000;
                                cnt_d    = 4'd0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                // One shift-add step per cycle; the stack is left untouched.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[14:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                cnt_d    = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB: begin
                // Replace the two operands with the product.
                load_s  = 1'b1;
                pop_s   = 1'b1;
                d_s     = acc_q;
                depth_d = depth_q - DEPTH_ONE;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            depth_q  <= {DW{1'b0}};
            err_q    <= 1'b0;
            mcand_q  <= 16'h0000;
            mplier_q <= 16'h0000;
            acc_q    <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        load  = load_s;
        push  = push_s;
        pop   = pop_s;
        d     = d_s;
        busy  = (state_q != ST_IDLE);
        err   = err_q;
        depth = depth_q;
    end

endmodule
